// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// Serial transmit path for the UART. Bytes arrive over a valid/ready
// handshake and go out as 8N1 frames on one serial line: a start bit (0),
// eight data bits LSB-first, then a stop bit (1). The line idles high.
//
// A one-byte holding buffer sits in front of the shift register. The next
// byte can be queued while a frame is still on the line, so consecutive
// frames follow each other with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst         synchronous, active-high reset
//   tx_data     byte to send; sampled when tx_valid && tx_ready
//   tx_valid    tx_data is valid
//   tx_ready    holding buffer is empty; a valid byte is taken this edge
//   serial_out  registered serial line, idle high
//   tx_busy     registered; high while a frame is in START, DATA or STOP
//   frame_done  one-cycle pulse in the cycle after the last stop-bit cycle
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       frame_done
);

    // A width of at least one bit keeps the counter legal for tiny periods.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [7:0]        hold_data;
    logic              hold_full;
    logic [7:0]        shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic              bit_end;
    logic              load;

    assign tx_ready = ~hold_full;

    // Last clock of the current serial bit period.
    assign bit_end = (bit_cnt == CNT_LAST);

    // The holding buffer moves into the shift register whenever a new frame
    // begins: straight from IDLE, or at the end of a stop bit so the next
    // start bit follows without a gap.
    assign load = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

    // Control: FSM, buffer occupancy, counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A load always empties the buffer; it cannot coincide with an
            // accept because a load requires the buffer to be full.
            if (load) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    bit_cnt    <= '0;
                    bit_idx    <= 3'd0;
                    if (hold_full) begin
                        state      <= START;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx    <= 3'd0;
                            state      <= STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            // The shift register moves right on this same
                            // edge, so bit 1 is the one that goes out next.
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                        if (hold_full) begin
                            state      <= START;
                            serial_out <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b1;
                            tx_busy    <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Data: the byte registers carry no reset; their contents only matter
    // once the control flags above mark them as occupied.
    always_ff @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            hold_data <= tx_data;
        end

        if (load) begin
            shift_reg <= hold_data;
        end else if ((state == DATA) && bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Bench for uart_tx_frame with CLKS_PER_BIT = 10. Each byte that the DUT
// accepts is pushed to a queue. A line monitor decodes frames from
// serial_out, pops the oldest queued byte and compares the two. The monitor
// also checks the start bit, the stop bit and frame_done at the frame end.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       serial_out;
    logic       tx_busy;
    logic       frame_done;

    uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         frames = 0;
    int         fd_cnt = 0;
    int         busy_cnt = 0;
    logic       aborting = 1'b1;
    logic [7:0] q[$];
    int         starts[$];

    // Monitor state
    logic       in_frame = 1'b0;
    int         t_in = 0;
    logic [7:0] got = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (tx_busy === 1'b1) busy_cnt++;
    end

    // Line monitor: decodes one frame at a time, sampling mid-bit.
    always @(negedge clk) begin
        if (aborting) begin
            in_frame = 1'b0;
            q.delete();
        end else begin
            if (in_frame) begin
                t_in++;
                if (t_in == 10 * C) begin
                    chk("frame_done_at_end", frame_done, 1);
                    in_frame = 1'b0;
                end
            end
            if (!in_frame && serial_out === 1'b0) begin
                in_frame = 1'b1;
                t_in = 0;
                starts.push_back(cyc);
            end
            if (in_frame && (t_in % C) == C / 2) begin
                int b;
                b = t_in / C;
                if (b == 0) begin
                    chk("start_bit", serial_out, 0);
                end else if (b <= 8) begin
                    got[b-1] = serial_out;
                end else begin
                    chk("stop_bit", serial_out, 1);
                    chk("queue_has_byte", (q.size() > 0), 1);
                    if (q.size() > 0) begin
                        logic [7:0] e;
                        e = q.pop_front();
                        chk("frame_byte", got, e);
                    end
                    frames++;
                end
            end
        end
    end

    // Offer a byte; junk data is shown while the DUT is not ready, so a
    // buffer that overwrites would be caught.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 3000) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            chk("send_ready_timeout", tx_ready, 1);
            tx_valid = 1'b0;
        end else begin
            tx_data = b;
            @(posedge clk);
            q.push_back(b);
            @(negedge clk);
            acc_cyc = cyc;
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx_busy !== 1'b0 || q.size() != 0 || tx_ready !== 1'b1) && n < 5000);
        repeat (3) @(negedge clk);
        chk("drain_queue", q.size(), 0);
        chk("drain_busy", tx_busy, 0);
    endtask

    initial begin
        int f0;
        int s0;
        int low;

        // 1. Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_serial", serial_out, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", frame_done, 0);
        aborting = 1'b0;
        repeat (2) @(negedge clk);

        // 2. Single frame 0xA5
        fd_cnt = 0;
        busy_cnt = 0;
        f0 = frames;
        s0 = starts.size();
        send(8'hA5);
        wait_idle();
        chk("a5_frames", frames - f0, 1);
        chk("a5_done_pulses", fd_cnt, 1);
        chk("a5_busy_cycles", busy_cnt, 100);
        chk("a5_start_seen", starts.size() - s0, 1);
        if (starts.size() > s0) chk("a5_latency", starts[s0] - acc_cyc, 1);

        // 3. Back-to-back 0x00 then 0xFF
        fd_cnt = 0;
        busy_cnt = 0;
        f0 = frames;
        s0 = starts.size();
        send(8'h00);
        send(8'hFF);
        wait_idle();
        chk("b2b_frames", frames - f0, 2);
        chk("b2b_done_pulses", fd_cnt, 2);
        chk("b2b_busy_cycles", busy_cnt, 200);
        chk("b2b_starts", starts.size() - s0, 2);
        if (starts.size() >= s0 + 2) chk("b2b_spacing", starts[s0+1] - starts[s0], 10 * C);

        // 4. Buffer full holds its byte while valid/data keep changing
        f0 = frames;
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        chk("full_not_ready", tx_ready, 0);
        send(8'h66);
        wait_idle();
        chk("hold_frames", frames - f0, 3);

        // 5. Reset in the middle of data bit 3
        f0 = frames;
        send(8'h96);
        repeat (1 + 4 * C + 3) @(negedge clk);
        aborting = 1'b1;
        rst = 1'b1;
        fd_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_serial", serial_out, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        aborting = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_no_done", fd_cnt, 0);
        chk("abort_no_frame", frames - f0, 0);
        fd_cnt = 0;
        send(8'h3C);
        wait_idle();
        chk("after_abort_frames", frames - f0, 1);
        chk("after_abort_done", fd_cnt, 1);

        // 6. Long idle
        fd_cnt = 0;
        busy_cnt = 0;
        low = 0;
        repeat (500) begin
            @(negedge clk);
            if (serial_out !== 1'b1) low++;
        end
        chk("idle_line_low", low, 0);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_done", fd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
